pipe_hazard_sequencer: RTL and testbench

// - Central stall/bubble sequencer for the 5-stage pipeline.
// - Drives the hold/squash controls of the PC, FD, DX, XM and MW pipeline registers.
// - Resolves three hazard classes:
//   - multi-cycle data-memory access in M;
//   - taken branch/jump resolved in M;
//   - load-use hazard between X and D.
// - Also counts stall cycles for performance monitoring.

---
 rtl/pipe_hazard_sequencer_if.sv | 41 ++++
 rtl/pipe_hazard_sequencer.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_sequencer_if.sv
// Hazard sequencer bus: the pipeline reports stage status and the
// sequencer returns hold/squash controls and its monitors.
interface pipe_hazard_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              m_req;
  logic              m_ready;
  logic              m_branch_taken;
  logic              x_is_load;
  logic [ADDR_W-1:0] x_dst;
  logic [ADDR_W-1:0] d_rs;
  logic [ADDR_W-1:0] d_rt;
  logic              d_use_rs;
  logic              d_use_rt;
  logic              pc_stall;
  logic              pc_redirect;
  logic              fd_stall;
  logic              fd_bubble;
  logic              dx_stall;
  logic              dx_bubble;
  logic              xm_stall;
  logic              xm_bubble;
  logic              mw_bubble;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cycles;

  modport slave (
    input  m_req, m_ready, m_branch_taken, x_is_load, x_dst, d_rs, d_rt,
           d_use_rs, d_use_rt,
    output pc_stall, pc_redirect, fd_stall, fd_bubble, dx_stall, dx_bubble,
           xm_stall, xm_bubble, mw_bubble, mem_err, stall_cycles
  );

  modport master (
    output m_req, m_ready, m_branch_taken, x_is_load, x_dst, d_rs, d_rt,
           d_use_rs, d_use_rt,
    input  pc_stall, pc_redirect, fd_stall, fd_bubble, dx_stall, dx_bubble,
           xm_stall, xm_bubble, mw_bubble, mem_err, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_sequencer.sv
// Central stall/bubble sequencer for the 5-stage pipeline. Resolves
// memory waits in M, taken branches in M and load-use between X and D,
// and counts stall cycles. Controls are combinational from state+inputs.
module pipe_hazard_sequencer #(
  parameter int ADDR_W       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipe_hazard_sequencer_if.slave bus
);
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX   = TW'(MEM_TIMEOUT);
  localparam logic [FW-1:0] FLUSH_LD  = FW'(FLUSH_CYCLES - 1);

  logic [1:0]       state, state_d;
  logic [TW-1:0]    tmo_cnt, tmo_d;
  logic [FW-1:0]    flush_cnt, flush_d;
  logic             mem_err_q, err_set;
  logic [CNT_W-1:0] stall_cnt;

  logic ld_use, mem_miss;
  logic c_pc_stall, c_pc_redirect, c_fd_stall, c_fd_bubble, c_dx_stall;
  logic c_dx_bubble, c_xm_stall, c_xm_bubble, c_mw_bubble;

  // r0 is hardwired, so a load targeting it never creates a dependency
  assign ld_use = bus.x_is_load && (bus.x_dst != ADDR_W'(0)) &&
                  ((bus.d_use_rs && (bus.d_rs == bus.x_dst)) ||
                   (bus.d_use_rt && (bus.d_rt == bus.x_dst)));
  assign mem_miss = bus.m_req && !bus.m_ready;

  // Next-state and raw control decode; priority mem wait > branch > load-use
  always_comb begin
    state_d       = state;
    tmo_d         = tmo_cnt;
    flush_d       = flush_cnt;
    err_set       = 1'b0;
    c_pc_stall    = 1'b0;
    c_pc_redirect = 1'b0;
    c_fd_stall    = 1'b0;
    c_fd_bubble   = 1'b0;
    c_dx_stall    = 1'b0;
    c_dx_bubble   = 1'b0;
    c_xm_stall    = 1'b0;
    c_xm_bubble   = 1'b0;
    c_mw_bubble   = 1'b0;
    case (state)
      RUN: begin
        if (mem_miss) begin
          {c_pc_stall, c_fd_stall, c_dx_stall, c_xm_stall, c_mw_bubble} = '1;
          tmo_d   = TW'(1);
          state_d = MEM_WAIT;
        end else if (bus.m_branch_taken) begin
          {c_pc_redirect, c_fd_bubble, c_dx_bubble, c_xm_bubble} = '1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            flush_d = FLUSH_LD;
          end
        end else if (ld_use) begin
          {c_pc_stall, c_fd_stall, c_dx_bubble} = '1;
        end
      end
      MEM_WAIT: begin
        if (bus.m_ready) begin
          state_d = RUN;
        end else if (tmo_cnt < TMO_MAX) begin
          {c_pc_stall, c_fd_stall, c_dx_stall, c_xm_stall, c_mw_bubble} = '1;
          tmo_d = tmo_cnt + TW'(1);
        end else begin
          // abort: let the pipe move on and squash the dead access in MW
          err_set     = 1'b1;
          c_mw_bubble = 1'b1;
          state_d     = RUN;
        end
      end
      FLUSH: begin
        if (mem_miss) begin
          {c_pc_stall, c_fd_stall, c_dx_stall, c_xm_stall, c_mw_bubble} = '1;
          tmo_d   = TW'(1);
          state_d = MEM_WAIT;
        end else begin
          c_fd_bubble = 1'b1;
          if (flush_cnt == FW'(1)) state_d = RUN;
          else                     flush_d = flush_cnt - FW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Reset forces every register to squash and nothing to hold
  assign bus.pc_stall     = rst_n & c_pc_stall;
  assign bus.pc_redirect  = rst_n & c_pc_redirect;
  assign bus.fd_stall     = rst_n & c_fd_stall;
  assign bus.dx_stall     = rst_n & c_dx_stall;
  assign bus.xm_stall     = rst_n & c_xm_stall;
  assign bus.fd_bubble    = !rst_n | c_fd_bubble;
  assign bus.dx_bubble    = !rst_n | c_dx_bubble;
  assign bus.xm_bubble    = !rst_n | c_xm_bubble;
  assign bus.mw_bubble    = !rst_n | c_mw_bubble;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cycles = stall_cnt;

  // FSM, wait/flush counters and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      tmo_cnt   <= '0;
      flush_cnt <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_d;
      tmo_cnt   <= tmo_d;
      flush_cnt <= flush_d;
      if (err_set) mem_err_q <= 1'b1;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       stall_cnt <= '0;
    else if (c_pc_stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed bench: table of single-cycle RUN decodes plus hand sequences
// for memory wait, timeout, flush, priority, reset and saturation.
module tb_pipe_hazard_sequencer;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  // control order: pc_stall pc_redirect fd_stall fd_bubble dx_stall dx_bubble xm_stall xm_bubble mw_bubble
  localparam logic [8:0] O_NONE   = 9'b000000000;
  localparam logic [8:0] O_LDUSE  = 9'b101001000;
  localparam logic [8:0] O_BRANCH = 9'b010101010;
  localparam logic [8:0] O_MEM    = 9'b101010101;
  localparam logic [8:0] O_RESET  = 9'b000101011;
  localparam logic [8:0] O_FLUSH  = 9'b000100000;
  localparam logic [8:0] O_ABORT  = 9'b000000001;

  typedef struct {
    string      name;
    logic       m_req, m_ready, br, ld;
    logic [4:0] x_dst, d_rs, d_rt;
    logic       use_rs, use_rt;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  pipe_hazard_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pipe_hazard_sequencer #(
    .ADDR_W(ADDR_W), .FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {bus.pc_stall, bus.pc_redirect, bus.fd_stall, bus.fd_bubble, bus.dx_stall,
            bus.dx_bubble, bus.xm_stall, bus.xm_bubble, bus.mw_bubble};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic rdy, input logic br, input logic ld,
                       input logic [4:0] xd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt);
    bus.m_req = mr; bus.m_ready = rdy; bus.m_branch_taken = br; bus.x_is_load = ld;
    bus.x_dst = xd; bus.d_rs = rs; bus.d_rt = rt; bus.d_use_rs = urs; bus.d_use_rt = urt;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // async reset pulse placed between clock edges
  task automatic pulse_reset();
    rst_n = 1'b0; #1; rst_n = 1'b1; #1;
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back('{"idle",        0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_NONE});
    tbl.push_back('{"lduse_rs",    0,0,0,1, 5'd5, 5'd5, 5'd1, 1,0, O_LDUSE});
    tbl.push_back('{"lduse_rt",    0,0,0,1, 5'd7, 5'd2, 5'd7, 0,1, O_LDUSE});
    tbl.push_back('{"lduse_r0",    0,0,0,1, 5'd0, 5'd0, 5'd0, 1,1, O_NONE});
    tbl.push_back('{"match_unused",0,0,0,1, 5'd9, 5'd9, 5'd9, 0,0, O_NONE});
    tbl.push_back('{"not_load",    0,0,0,0, 5'd5, 5'd5, 5'd5, 1,1, O_NONE});
    tbl.push_back('{"no_match",    0,0,0,1, 5'd5, 5'd4, 5'd6, 1,1, O_NONE});
    tbl.push_back('{"mem_hit",     1,1,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_NONE});
    tbl.push_back('{"branch",      0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, O_BRANCH});
    tbl.push_back('{"br_over_lu",  0,0,1,1, 5'd3, 5'd3, 5'd0, 1,0, O_BRANCH});
    tbl.push_back('{"mem_miss",    1,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_MEM});
    tbl.push_back('{"mem_over_all",1,0,1,1, 5'd3, 5'd3, 5'd3, 1,1, O_MEM});

    // reset held with random inputs
    drive($urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
          5'($urandom), $urandom, $urandom);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outs", 32'(outs()), 32'(O_RESET));
    chk("reset_cnt", 32'(bus.stall_cycles), 0);
    chk("reset_err", 32'(bus.mem_err), 0);
    idle();
    rst_n = 1'b1;

    // table: RUN-state decode, reset between entries
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].m_req, tbl[i].m_ready, tbl[i].br, tbl[i].ld, tbl[i].x_dst,
            tbl[i].d_rs, tbl[i].d_rt, tbl[i].use_rs, tbl[i].use_rt);
      #1 chk(tbl[i].name, 32'(outs()), 32'(tbl[i].exp));
      idle();
      pulse_reset();
    end

    // load-use for one cycle
    @(negedge clk); drive(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    #1 chk("lu_c1", 32'(outs()), 32'(O_LDUSE));
    @(negedge clk); idle();
    #1 chk("lu_c2", 32'(outs()), 32'(O_NONE));
    chk("lu_cnt", 32'(bus.stall_cycles), 1);
    pulse_reset();

    // memory wait: 3 miss cycles then ready
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("mw_stall%0d", k), 32'(outs()), 32'(O_MEM));
      @(negedge clk);
    end
    bus.m_ready = 1'b1;
    #1 chk("mw_release", 32'(outs()), 32'(O_NONE));
    @(negedge clk); idle();
    #1 chk("mw_run", 32'(outs()), 32'(O_NONE));
    chk("mw_cnt", 32'(bus.stall_cycles), 3);
    chk("mw_err", 32'(bus.mem_err), 0);
    pulse_reset();

    // branch with two flush cycles
    @(negedge clk); drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("br_c1", 32'(outs()), 32'(O_BRANCH));
    @(negedge clk); idle();
    #1 chk("br_flush", 32'(outs()), 32'(O_FLUSH));
    @(negedge clk);
    #1 chk("br_done", 32'(outs()), 32'(O_NONE));
    pulse_reset();

    // memory miss arriving during FLUSH takes over
    @(negedge clk); drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("fl_mem", 32'(outs()), 32'(O_MEM));
    @(negedge clk); bus.m_ready = 1'b1;
    #1 chk("fl_mem_rel", 32'(outs()), 32'(O_NONE));
    @(negedge clk); idle();
    #1 chk("fl_run", 32'(outs()), 32'(O_NONE));
    pulse_reset();

    // timeout: 4 stall cycles, then abort with mw_bubble only
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("to_stall%0d", k), 32'(outs()), 32'(O_MEM));
      @(negedge clk);
    end
    #1 chk("to_abort", 32'(outs()), 32'(O_ABORT));
    chk("to_err_pre", 32'(bus.mem_err), 0);
    @(negedge clk); idle();
    #1 chk("to_err", 32'(bus.mem_err), 1);
    chk("to_outs", 32'(outs()), 32'(O_NONE));
    chk("to_cnt", 32'(bus.stall_cycles), 4);
    @(negedge clk);
    #1 chk("to_err_sticky", 32'(bus.mem_err), 1);
    pulse_reset();
    chk("to_err_clr", 32'(bus.mem_err), 0);

    // priority, then reset mid-MEM_WAIT
    @(negedge clk); drive(1, 0, 1, 1, 5'd3, 5'd3, 5'd3, 1, 1);
    #1 chk("pr_c1", 32'(outs()), 32'(O_MEM));
    @(negedge clk);
    #1 chk("pr_wait", 32'(outs()), 32'(O_MEM));
    rst_n = 1'b0; #1;
    chk("pr_rst_outs", 32'(outs()), 32'(O_RESET));
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("pr_back_run", 32'(outs()), 32'(O_BRANCH));
    idle();
    pulse_reset();

    // saturation of the stall counter
    @(negedge clk); drive(0, 0, 0, 1, 5'd6, 5'd6, 5'd0, 1, 0);
    repeat (20) @(negedge clk);
    #1 chk("sat_cnt", 32'(bus.stall_cycles), 15);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
